// File: rtl/wb_trace_buffer_pkg.sv
// Shared record layout for the write-back trace buffer.
package wb_trace_buffer_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned WNUM_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned TRACE_REC_W = PC_W + STRB_W + WNUM_W + DATA_W;

  // Record layout, LSB first: wdata | wnum | wstrb | pc
  localparam int unsigned REC_WDATA_LSB = 0;
  localparam int unsigned REC_WNUM_LSB  = REC_WDATA_LSB + DATA_W;
  localparam int unsigned REC_WSTRB_LSB = REC_WNUM_LSB + WNUM_W;
  localparam int unsigned REC_PC_LSB    = REC_WSTRB_LSB + STRB_W;

  function automatic logic [TRACE_REC_W-1:0] pack_rec(input logic [PC_W-1:0]   pc,
                                                      input logic [STRB_W-1:0] wstrb,
                                                      input logic [WNUM_W-1:0] wnum,
                                                      input logic [DATA_W-1:0] wdata);
    return {pc, wstrb, wnum, wdata};
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Write-back debug input and trace output port bundle.
interface wb_trace_buffer_if;
  import wb_trace_buffer_pkg::*;

  logic              wb_retire;
  logic [PC_W-1:0]   debug_wb_pc;
  logic [STRB_W-1:0] debug_wb_rf_we;
  logic [WNUM_W-1:0] debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;

  logic              trace_valid;
  logic              trace_ready;
  logic [PC_W-1:0]   trace_pc;
  logic [WNUM_W-1:0] trace_wnum;
  logic [DATA_W-1:0] trace_wdata;
  logic [STRB_W-1:0] trace_wstrb;

  // Core / consumer side
  modport master (
    output wb_retire, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output trace_ready,
    input  trace_valid, trace_pc, trace_wnum, trace_wdata, trace_wstrb
  );

  // Trace buffer side
  modport slave (
    input  wb_retire, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  trace_ready,
    output trace_valid, trace_pc, trace_wnum, trace_wdata, trace_wstrb
  );

endinterface

// File: rtl/trace_sync_fifo.sv
// Generic single-clock FIFO; head reads zero when empty.
module trace_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       rdata
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; a push into a full FIFO only lands alongside a pop
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; when full, the write slot is the head being popped this cycle
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures GPR-writing retirements into a FIFO and drains them on a valid/ready trace port.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_trace_buffer_if.slave       bus,
  input  logic                   stat_clear,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [31:0]            retire_cnt,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   overflow
);

  logic                   cap, push, pop, drop, full, empty;
  logic [TRACE_REC_W-1:0] rec_in, head;
  logic [31:0]            retire_cnt_q, retire_cnt_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic                   overflow_q, overflow_d;

  assign cap  = bus.wb_retire & (|bus.debug_wb_rf_we) & (bus.debug_wb_rf_wnum != '0);
  assign pop  = bus.trace_valid & bus.trace_ready;
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  assign rec_in = pack_rec(bus.debug_wb_pc, bus.debug_wb_rf_we, bus.debug_wb_rf_wnum,
                           bus.debug_wb_rf_wdata);

  trace_sync_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (rec_in),
    .full  (full),
    .empty (empty),
    .count (fifo_count),
    .rdata (head)
  );

  assign bus.trace_valid = ~empty;
  assign bus.trace_pc    = head[REC_PC_LSB +: PC_W];
  assign bus.trace_wstrb = head[REC_WSTRB_LSB +: STRB_W];
  assign bus.trace_wnum  = head[REC_WNUM_LSB +: WNUM_W];
  assign bus.trace_wdata = head[REC_WDATA_LSB +: DATA_W];

  // Statistics next-state; a clear overrides any same-cycle increment
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q;
    if (stat_clear) begin
      retire_cnt_d = '0;
      drop_cnt_d   = '0;
      overflow_d   = 1'b0;
    end else begin
      if (bus.wb_retire) retire_cnt_d = retire_cnt_q + 32'd1;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios plus random traffic vs a queue model.
module tb_wb_trace_buffer;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DROP_W = 16;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              stat_clear;
  logic [3:0]        fifo_count;
  logic [31:0]       retire_cnt;
  logic [DROP_W-1:0] drop_cnt;
  logic              overflow;

  wb_trace_buffer_if bus ();

  wb_trace_buffer #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .stat_clear (stat_clear),
    .fifo_count (fifo_count),
    .retire_cnt (retire_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  rec_t              mq[$];
  logic [31:0]       m_retire;
  logic [DROP_W-1:0] m_drop;
  logic              m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every observable output with the model's current state
  task automatic compare_model();
    rec_t h;
    h = '{pc: '0, we: '0, wnum: '0, wdata: '0};
    if (mq.size() != 0) h = mq[0];
    check("valid", 32'(bus.trace_valid), (mq.size() != 0) ? 32'd1 : 32'd0);
    check("pc", bus.trace_pc, h.pc);
    check("wstrb", 32'(bus.trace_wstrb), 32'(h.we));
    check("wnum", 32'(bus.trace_wnum), 32'(h.wnum));
    check("wdata", bus.trace_wdata, h.wdata);
    check("count", 32'(fifo_count), mq.size());
    check("retire_cnt", retire_cnt, m_retire);
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_update();
    bit   full, pop, cap;
    rec_t r;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && bus.trace_ready;
    cap  = bus.wb_retire && (bus.debug_wb_rf_we != 0) && (bus.debug_wb_rf_wnum != 0);
    if (reset) begin
      mq.delete();
      m_retire = '0;
      m_drop   = '0;
      m_ovf    = 1'b0;
      return;
    end
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (!full || pop) begin
        r = '{pc: bus.debug_wb_pc, we: bus.debug_wb_rf_we, wnum: bus.debug_wb_rf_wnum,
              wdata: bus.debug_wb_rf_wdata};
        mq.push_back(r);
      end else begin
        if (m_drop != {DROP_W{1'b1}}) m_drop = m_drop + 1'b1;
        m_ovf = 1'b1;
      end
    end
    if (stat_clear) begin
      m_retire = '0;
      m_drop   = '0;
      m_ovf    = 1'b0;
    end else if (bus.wb_retire) begin
      m_retire = m_retire + 32'd1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit retire, input logic [31:0] pc, input logic [3:0] we,
                       input logic [4:0] wnum, input logic [31:0] wdata, input bit ready,
                       input bit clr);
    bus.wb_retire         = retire;
    bus.debug_wb_pc       = pc;
    bus.debug_wb_rf_we    = we;
    bus.debug_wb_rf_wnum  = wnum;
    bus.debug_wb_rf_wdata = wdata;
    bus.trace_ready       = ready;
    stat_clear            = clr;
    step();
  endtask

  task automatic idle(input int n, input bit ready);
    repeat (n) drive(1'b0, '0, '0, '0, '0, ready, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1, 1'b0);
    reset = 1'b0;
  endtask

  logic [31:0] pcs [10];

  initial begin
    reset = 1'b1;
    stat_clear = 1'b0;
    bus.wb_retire = 1'b0;
    bus.debug_wb_pc = '0;
    bus.debug_wb_rf_we = '0;
    bus.debug_wb_rf_wnum = '0;
    bus.debug_wb_rf_wdata = '0;
    bus.trace_ready = 1'b1;
    mq.delete();
    m_retire = '0;
    m_drop = '0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Idle after reset
    idle(20, 1'b1);
    check("idle_valid", 32'(bus.trace_valid), 0);
    check("idle_count", 32'(fifo_count), 0);

    // Single retire, one-cycle latency
    drive(1'b1, 32'h1c00_0000, 4'hF, 5'd5, 32'h1234_5678, 1'b1, 1'b0);
    check("single_valid", 32'(bus.trace_valid), 1);
    check("single_pc", bus.trace_pc, 32'h1c00_0000);
    check("single_wnum", 32'(bus.trace_wnum), 5);
    check("single_wdata", bus.trace_wdata, 32'h1234_5678);
    check("single_wstrb", 32'(bus.trace_wstrb), 32'hF);
    idle(1, 1'b1);
    check("single_drained", 32'(fifo_count), 0);
    check("single_retire", retire_cnt, 1);

    // Filtered retires
    do_reset();
    drive(1'b1, 32'h1c00_0004, 4'hF, 5'd0, 32'hdead_beef, 1'b1, 1'b0);
    check("filt_r0_retire", retire_cnt, 1);
    check("filt_r0_count", 32'(fifo_count), 0);
    drive(1'b1, 32'h1c00_0008, 4'h0, 5'd7, 32'hcafe_f00d, 1'b1, 1'b0);
    check("filt_we0_retire", retire_cnt, 2);
    check("filt_we0_count", 32'(fifo_count), 0);
    idle(2, 1'b1);

    // Fill and overflow
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pcs[i] = 32'h1000 + 32'(i * 4);
      drive(1'b1, pcs[i], 4'hF, 5'(i + 1), $urandom, 1'b0, 1'b0);
    end
    check("fill_count", 32'(fifo_count), 8);
    check("fill_drop", 32'(drop_cnt), 2);
    check("fill_ovf", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", bus.trace_pc, pcs[i]);
      idle(1, 1'b1);
    end
    check("drain_empty", 32'(bus.trace_valid), 0);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, pcs[i], 4'h3, 5'(i + 9), $urandom, 1'b0, 1'b0);
    drive(1'b1, 32'hABCD_0000, 4'hC, 5'd31, 32'h5555_aaaa, 1'b1, 1'b0);
    check("pp_count", 32'(fifo_count), 8);
    check("pp_drop", 32'(drop_cnt), 0);
    for (int i = 1; i < 8; i++) begin
      check("pp_order", bus.trace_pc, pcs[i]);
      idle(1, 1'b1);
    end
    check("pp_new_8th", bus.trace_pc, 32'hABCD_0000);
    idle(2, 1'b1);

    // stat_clear against a concurrent retire and drop
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, pcs[i], 4'hF, 5'(i + 1), $urandom, 1'b0, 1'b0);
    idle(1, 1'b0);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'h2000, 4'hF, 5'd0, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h2004, 4'h0, 5'd3, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h3000, 4'hF, 5'd4, $urandom, 1'b0, 1'b0);
    check("pre_clr_retire", retire_cnt, 5);
    check("pre_clr_drop", 32'(drop_cnt), 3);
    drive(1'b1, 32'h4000, 4'hF, 5'd6, $urandom, 1'b0, 1'b1);
    check("clr_retire", retire_cnt, 0);
    check("clr_drop", 32'(drop_cnt), 0);
    check("clr_ovf", 32'(overflow), 0);
    check("clr_count", 32'(fifo_count), 8);
    check("clr_head", bus.trace_pc, pcs[0]);
    idle(10, 1'b1);

    // Random traffic with varying back-pressure
    begin
      int unsigned ready_pct = 50;
      for (int c = 0; c < 3000; c++) begin
        bit          r, rdy, clr;
        logic [3:0]  we;
        logic [4:0]  wn;
        if (c % 200 == 0) ready_pct = $urandom_range(0, 100);
        reset = ($urandom_range(0, 599) == 0);
        r   = ($urandom_range(0, 3) != 0);
        we  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
        wn  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        rdy = ($urandom_range(0, 99) < ready_pct);
        clr = ($urandom_range(0, 49) == 0);
        drive(r, $urandom, we, wn, $urandom, rdy, clr);
      end
      reset = 1'b0;
      idle(12, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
